// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches through a req/ack handshake and
// loads the IF/ID register. Optional macro DELAY_SLOT_EN keeps the post-jump word.
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        jump_en,
  input  logic [15:0] jump_addr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic [15:0] inst_pc1,
  output logic        inst_valid
);

  typedef enum logic [0:0] {FETCH = 1'b0, HOLD = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [15:0] redir_addr_q, redir_addr_d;
  logic [15:0] buf_inst_q, buf_inst_d;
  logic [15:0] buf_pc_q, buf_pc_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] inst_pc_q, inst_pc_d;
  logic [15:0] inst_pc1_q, inst_pc1_d;
  logic        inst_valid_q, inst_valid_d;

  logic        cand_s;
  logic [15:0] cand_inst_s;
  logic [15:0] cand_pc_s;
  logic        redir_s;
  logic [15:0] redir_tgt_s;

  // Next-state logic: fetch/redirect handling, then IF/ID and skid-buffer update
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    redir_addr_d = redir_addr_q;
    buf_inst_d   = buf_inst_q;
    buf_pc_d     = buf_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_pc1_d   = inst_pc1_q;
    inst_valid_d = inst_valid_q;
    cand_s       = 1'b0;
    cand_inst_s  = buf_inst_q;
    cand_pc_s    = buf_pc_q;
    redir_s      = redir_pend_q | jump_en;
    redir_tgt_s  = jump_en ? jump_addr : redir_addr_q;

    if (jump_en) begin
      redir_pend_d = 1'b1;
      redir_addr_d = jump_addr;
    end else begin
      redir_pend_d = redir_pend_q;
      redir_addr_d = redir_addr_q;
    end

    // cand_s marks a word that is ready to enter IF/ID this cycle
    case (state_q)
      FETCH: begin
        cand_inst_s = imem_rdata;
        cand_pc_s   = pc_q;
        if (imem_ack) begin
          redir_pend_d = 1'b0;
          if (redir_s) begin
            pc_d = redir_tgt_s;
`ifdef DELAY_SLOT_EN
            cand_s = 1'b1;
`else
            cand_s = 1'b0;
`endif
          end else begin
            pc_d   = pc_q + 16'd1;
            cand_s = 1'b1;
          end
        end else begin
          pc_d = pc_q;
        end
      end
      HOLD: begin
        cand_s = 1'b1;
        if (jump_en) begin
          redir_pend_d = 1'b0;
          pc_d         = jump_addr;
`ifndef DELAY_SLOT_EN
          cand_s  = 1'b0;
          state_d = FETCH;
`endif
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // A word that cannot enter IF/ID (flush or stall) parks in the buffer
    if (flush) begin
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
      if (cand_s) begin
        state_d    = HOLD;
        buf_inst_d = cand_inst_s;
        buf_pc_d   = cand_pc_s;
      end else begin
        buf_inst_d = buf_inst_q;
      end
    end else if (stall) begin
      if (cand_s) begin
        state_d    = HOLD;
        buf_inst_d = cand_inst_s;
        buf_pc_d   = cand_pc_s;
      end else begin
        buf_inst_d = buf_inst_q;
      end
`ifndef DELAY_SLOT_EN
    end else if (jump_en) begin
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
`endif
    end else if (cand_s) begin
      state_d      = FETCH;
      inst_d       = cand_inst_s;
      inst_pc_d    = cand_pc_s;
      inst_pc1_d   = cand_pc_s + 16'd1;
      inst_valid_d = 1'b1;
    end else begin
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
    end
  end

  // State, PC, redirect, buffer and IF/ID registers
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_addr_q <= 16'h0000;
      buf_inst_q   <= NOP_INST;
      buf_pc_q     <= 16'h0000;
      inst_q       <= NOP_INST;
      inst_pc_q    <= 16'h0000;
      inst_pc1_q   <= 16'h0001;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      redir_addr_q <= redir_addr_d;
      buf_inst_q   <= buf_inst_d;
      buf_pc_q     <= buf_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_pc1_q   <= inst_pc1_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // The request is held low while reset is asserted so it drops immediately
  assign imem_req   = (state_q == FETCH) & ~rst;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_pc1   = inst_pc1_q;
  assign inst_valid = inst_valid_q;

endmodule
